// File: rtl/tmr_scrub_ctrl.sv
// tmr_scrub_ctrl: scrub sequencer and replica health monitor
// for a triple-modular-redundant counter.
module tmr_scrub_ctrl #(
    parameter int width        = 64,
    parameter int cnt_w        = 8,
    parameter int scrub_period = 16,
    parameter int fail_thresh  = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             stop,
    input  logic [width-1:0] q_1,
    input  logic [width-1:0] q_2,
    input  logic [width-1:0] q_3,
    output logic             enable,
    output logic             resync,
    output logic [cnt_w-1:0] fault_cnt_1,
    output logic [cnt_w-1:0] fault_cnt_2,
    output logic [cnt_w-1:0] fault_cnt_3,
    output logic [2:0]       replica_failed,
    output logic             alarm,
    output logic [2:0]       state
);

    localparam int TW = $clog2(scrub_period);
    localparam logic [TW-1:0] RELOAD = TW'(scrub_period - 1);
    localparam logic [3:0] THR = 4'(fail_thresh);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_RUN    = 3'd1,
        S_CHECK  = 3'd2,
        S_RESYNC = 3'd3,
        S_HALT   = 3'd4
    } state_t;

    state_t                  state_q;
    logic [TW-1:0]           timer_q;
    logic                    enable_q;
    logic                    resync_q;
    logic                    alarm_q;
    logic [2:0][cnt_w-1:0]   fcnt_q;
    logic [2:0][cnt_w-1:0]   fcnt_d;
    logic [2:0][3:0]         cons_q;
    logic [2:0][3:0]         cons_d;
    logic [2:0]              failed_q;
    logic [2:0]              failed_d;
    logic [2:0]              faulty_q;

    logic                    e12;
    logic                    e13;
    logic                    e23;
    logic                    maj_ok;
    logic [width-1:0]        maj_val;
    logic [2:0]              faulty_now;
    logic                    two_failed;

    // Majority vote and per-replica disagreement with it.
    always_comb begin
        e12 = (q_1 == q_2);
        e13 = (q_1 == q_3);
        e23 = (q_2 == q_3);
        maj_ok = e12 | e13 | e23;
        maj_val = (e12 | e13) ? q_1 : q_2;
        faulty_now[0] = maj_ok && (q_1 != maj_val);
        faulty_now[1] = maj_ok && (q_2 != maj_val);
        faulty_now[2] = maj_ok && (q_3 != maj_val);
    end

    // Statistics as they will stand after the RESYNC cycle.
    always_comb begin
        fcnt_d = fcnt_q;
        cons_d = cons_q;
        failed_d = failed_q;
        for (int i = 0; i < 3; i++) begin
            if (faulty_q[i]) begin
                if (fcnt_q[i] != {cnt_w{1'b1}}) begin
                    fcnt_d[i] = fcnt_q[i] + cnt_w'(1);
                end
                if (cons_q[i] != 4'hf) begin
                    cons_d[i] = cons_q[i] + 4'd1;
                end
                if (cons_d[i] >= THR) begin
                    failed_d[i] = 1'b1;
                end
            end else begin
                cons_d[i] = 4'd0;
            end
        end
        two_failed = (failed_d[0] & failed_d[1])
                   | (failed_d[0] & failed_d[2])
                   | (failed_d[1] & failed_d[2]);
    end

    // Sequencer with registered outputs matching the next state.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= S_IDLE;
            timer_q  <= '0;
            enable_q <= 1'b0;
            resync_q <= 1'b0;
            alarm_q  <= 1'b0;
            fcnt_q   <= '0;
            cons_q   <= '0;
            failed_q <= '0;
            faulty_q <= '0;
        end else begin
            enable_q <= 1'b0;
            resync_q <= 1'b0;
            alarm_q  <= 1'b0;
            unique case (state_q)
                S_IDLE: begin
                    if (start && !stop) begin
                        state_q  <= S_RUN;
                        timer_q  <= RELOAD;
                        enable_q <= 1'b1;
                    end
                end
                S_RUN: begin
                    if (!maj_ok) begin
                        state_q <= S_HALT;
                        alarm_q <= 1'b1;
                    end else if (stop) begin
                        state_q <= S_IDLE;
                    end else if (timer_q == '0) begin
                        state_q <= S_CHECK;
                    end else begin
                        timer_q  <= timer_q - TW'(1);
                        enable_q <= 1'b1;
                    end
                end
                S_CHECK: begin
                    faulty_q <= faulty_now;
                    if (!maj_ok) begin
                        state_q <= S_HALT;
                        alarm_q <= 1'b1;
                    end else if (|faulty_now) begin
                        state_q  <= S_RESYNC;
                        resync_q <= 1'b1;
                    end else begin
                        state_q  <= S_RUN;
                        timer_q  <= RELOAD;
                        enable_q <= 1'b1;
                        cons_q   <= '0;
                    end
                end
                S_RESYNC: begin
                    fcnt_q   <= fcnt_d;
                    cons_q   <= cons_d;
                    failed_q <= failed_d;
                    if (two_failed) begin
                        state_q <= S_HALT;
                        alarm_q <= 1'b1;
                    end else if (stop) begin
                        state_q <= S_IDLE;
                    end else begin
                        state_q  <= S_RUN;
                        timer_q  <= RELOAD;
                        enable_q <= 1'b1;
                    end
                end
                S_HALT: begin
                    alarm_q <= 1'b1;
                end
                default: begin
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

    assign enable         = enable_q;
    assign resync         = resync_q;
    assign alarm          = alarm_q;
    assign state          = state_q;
    assign replica_failed = failed_q;
    assign fault_cnt_1    = fcnt_q[0];
    assign fault_cnt_2    = fcnt_q[1];
    assign fault_cnt_3    = fcnt_q[2];

endmodule

// File: tb/tb_tmr_scrub_ctrl.sv
// tb_tmr_scrub_ctrl: directed scoreboard bench for the
// TMR scrub controller (cnt_w=2 to exercise saturation).
module tb_tmr_scrub_ctrl;

    localparam int W  = 64;
    localparam int CW = 2;
    localparam int SP = 16;

    logic          clk = 1'b0;
    logic          rst;
    logic          start;
    logic          stop;
    logic [W-1:0]  q_1;
    logic [W-1:0]  q_2;
    logic [W-1:0]  q_3;
    logic          enable;
    logic          resync;
    logic [CW-1:0] fault_cnt_1;
    logic [CW-1:0] fault_cnt_2;
    logic [CW-1:0] fault_cnt_3;
    logic [2:0]    replica_failed;
    logic          alarm;
    logic [2:0]    state;

    logic [W-1:0]  tcnt;
    logic [2:0]    ov_en;
    logic [W-1:0]  ov1;
    logic [W-1:0]  ov2;
    logic [W-1:0]  ov3;

    int cyc = 0;
    int n_vec = 0;
    int n_bad = 0;

    int e_f1 = 0;
    int e_f2 = 0;
    int e_f3 = 0;
    logic [2:0] e_rf = 3'b000;

    typedef struct {
        int            due;
        string         nm;
        logic [2:0]    st;
        logic          en;
        logic          rs;
        logic          al;
        logic [2:0]    rf;
        logic [CW-1:0] f1;
        logic [CW-1:0] f2;
        logic [CW-1:0] f3;
    } exp_t;

    exp_t sb[$];

    tmr_scrub_ctrl #(
        .width(W),
        .cnt_w(CW),
        .scrub_period(SP),
        .fail_thresh(4)
    ) dut (
        .clk(clk),
        .rst(rst),
        .start(start),
        .stop(stop),
        .q_1(q_1),
        .q_2(q_2),
        .q_3(q_3),
        .enable(enable),
        .resync(resync),
        .fault_cnt_1(fault_cnt_1),
        .fault_cnt_2(fault_cnt_2),
        .fault_cnt_3(fault_cnt_3),
        .replica_failed(replica_failed),
        .alarm(alarm),
        .state(state)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Ideal replica: counts whenever the controller enables it.
    always @(posedge clk) begin
        if (rst) tcnt <= '0;
        else if (enable) tcnt <= tcnt + 64'd1;
    end

    assign q_1 = ov_en[0] ? ov1 : tcnt;
    assign q_2 = ov_en[1] ? ov2 : tcnt;
    assign q_3 = ov_en[2] ? ov3 : tcnt;

    // Monitor: pops expectations due this cycle, compares mid-cycle.
    always @(negedge clk) begin : mon
        exp_t e;
        while (sb.size() > 0 && sb[0].due <= cyc) begin
            e = sb.pop_front();
            n_vec++;
            if (e.due != cyc || state !== e.st || enable !== e.en ||
                resync !== e.rs || alarm !== e.al ||
                replica_failed !== e.rf || fault_cnt_1 !== e.f1 ||
                fault_cnt_2 !== e.f2 || fault_cnt_3 !== e.f3) begin
                n_bad++;
                $display("FAIL %s @%0d: got st=%0d en=%0b rs=%0b al=%0b rf=%b fc=%0d/%0d/%0d want st=%0d en=%0b rs=%0b al=%0b rf=%b fc=%0d/%0d/%0d",
                         e.nm, cyc, state, enable, resync, alarm,
                         replica_failed, fault_cnt_1, fault_cnt_2,
                         fault_cnt_3, e.st, e.en, e.rs, e.al, e.rf,
                         e.f1, e.f2, e.f3);
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Queue the expected outputs for the current cycle.
    task automatic chk(input string nm, input logic [2:0] st);
        exp_t e;
        e.due = cyc;
        e.nm  = nm;
        e.st  = st;
        e.en  = (st == 3'd1);
        e.rs  = (st == 3'd3);
        e.al  = (st == 3'd4);
        e.rf  = e_rf;
        e.f1  = CW'(e_f1);
        e.f2  = CW'(e_f2);
        e.f3  = CW'(e_f3);
        sb.push_back(e);
    endtask

    // From the first RUN cycle of a period up to its CHECK cycle.
    task automatic run_to_check();
        for (int i = 0; i < SP; i++) begin
            chk("run", 3'd1);
            tick();
        end
        chk("check", 3'd2);
    endtask

    // One period with a single bad replica injected at CHECK.
    task automatic fault_period(input logic [2:0] bad,
                                input int f1, input int f2, input int f3,
                                input logic [2:0] rf,
                                input logic [2:0] nst);
        run_to_check();
        ov1 = tcnt ^ 64'h5;
        ov2 = tcnt ^ 64'h5;
        ov3 = tcnt ^ 64'h5;
        ov_en = bad;
        tick();
        chk("fault_resync", 3'd3);
        tick();
        e_f1 = f1;
        e_f2 = f2;
        e_f3 = f3;
        e_rf = rf;
        chk("fault_after", nst);
        ov_en = 3'b000;
    endtask

    initial begin
        rst = 1'b1;
        start = 1'b0;
        stop = 1'b0;
        ov_en = 3'b000;
        ov1 = '0;
        ov2 = '0;
        ov3 = '0;
        tick();
        tick();
        rst = 1'b0;
        chk("reset", 3'd0);

        start = 1'b1;
        stop = 1'b1;
        tick();
        chk("start_stop", 3'd0);
        tick();
        chk("start_stop2", 3'd0);
        stop = 1'b0;
        tick();
        chk("run_entry", 3'd1);
        start = 1'b0;

        for (int p = 0; p < 2; p++) begin
            run_to_check();
            tick();
        end

        run_to_check();
        ov_en = 3'b111;
        ov1 = 64'h9;
        ov2 = 64'h5;
        ov3 = 64'h9;
        tick();
        chk("minor_resync", 3'd3);
        tick();
        e_f2 = 1;
        chk("minor_resume", 3'd1);
        ov_en = 3'b000;

        fault_period(3'b100, 0, 1, 1, 3'b000, 3'd1);
        fault_period(3'b100, 0, 1, 2, 3'b000, 3'd1);
        fault_period(3'b100, 0, 1, 3, 3'b000, 3'd1);
        run_to_check();
        tick();
        chk("clean_check", 3'd1);
        fault_period(3'b100, 0, 1, 3, 3'b000, 3'd1);
        fault_period(3'b100, 0, 1, 3, 3'b000, 3'd1);
        fault_period(3'b100, 0, 1, 3, 3'b000, 3'd1);
        fault_period(3'b100, 0, 1, 3, 3'b100, 3'd1);

        run_to_check();
        ov3 = tcnt ^ 64'h5;
        ov_en = 3'b100;
        stop = 1'b1;
        tick();
        chk("stop_resync", 3'd3);
        tick();
        chk("stop_idle", 3'd0);
        stop = 1'b0;
        ov_en = 3'b000;
        tick();
        chk("idle_hold", 3'd0);

        rst = 1'b1;
        tick();
        rst = 1'b0;
        e_f1 = 0;
        e_f2 = 0;
        e_f3 = 0;
        e_rf = 3'b000;
        chk("reset2", 3'd0);
        start = 1'b1;
        tick();
        chk("run2", 3'd1);
        start = 1'b0;
        fault_period(3'b001, 1, 0, 0, 3'b000, 3'd1);
        fault_period(3'b001, 2, 0, 0, 3'b000, 3'd1);
        fault_period(3'b001, 3, 0, 0, 3'b000, 3'd1);
        fault_period(3'b001, 3, 0, 0, 3'b001, 3'd1);
        fault_period(3'b001, 3, 0, 0, 3'b001, 3'd1);
        fault_period(3'b010, 3, 1, 0, 3'b001, 3'd1);
        fault_period(3'b010, 3, 2, 0, 3'b001, 3'd1);
        fault_period(3'b010, 3, 3, 0, 3'b001, 3'd1);
        fault_period(3'b010, 3, 3, 0, 3'b011, 3'd4);
        tick();
        chk("halt_hold", 3'd4);

        rst = 1'b1;
        tick();
        rst = 1'b0;
        e_f1 = 0;
        e_f2 = 0;
        e_f3 = 0;
        e_rf = 3'b000;
        chk("reset3", 3'd0);
        start = 1'b1;
        tick();
        chk("run3", 3'd1);
        start = 1'b0;
        tick();
        chk("run3b", 3'd1);
        ov1 = 64'h1;
        ov2 = 64'h2;
        ov3 = 64'h3;
        ov_en = 3'b111;
        tick();
        chk("nomaj_halt", 3'd4);
        start = 1'b1;
        tick();
        chk("halt_start", 3'd4);
        start = 1'b0;
        stop = 1'b1;
        tick();
        chk("halt_stop", 3'd4);
        ov_en = 3'b000;
        start = 1'b1;
        stop = 1'b0;
        tick();
        chk("halt_clean", 3'd4);
        start = 1'b0;

        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("reset4", 3'd0);
        start = 1'b1;
        tick();
        start = 1'b0;
        run_to_check();
        ov1 = tcnt ^ 64'h5;
        ov_en = 3'b001;
        tick();
        chk("pre_rst_resync", 3'd3);
        rst = 1'b1;
        tick();
        chk("rst_mid_resync", 3'd0);
        rst = 1'b0;
        ov_en = 3'b000;
        tick();
        chk("post_rst", 3'd0);

        tick();
        tick();
        if (sb.size() != 0) begin
            n_vec++;
            n_bad++;
            $display("FAIL drain: got %0d pending, want 0", sb.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==",
                 n_vec, n_bad);
        $finish;
    end

endmodule

// File: doc/tmr_scrub_ctrl.md
# tmr_scrub_ctrl

Sequencing and health-monitoring controller for the triple-modular-redundant counter. It gates the counter's `enable` and pauses counting every `scrub_period` cycles to compare the three replica outputs. On a minority mismatch it issues a one-cycle `resync` pulse, and it keeps saturating per-replica fault statistics. A replica that mismatches at `fail_thresh` consecutive checks is declared failed; loss of majority halts the counter.

## Interface
Parameters:
- `width`, 64, width of each replica count value
- `cnt_w`, 8, width of each saturating fault counter
- `scrub_period`, 16, RUN cycles between checks (≥2)
- `fail_thresh`, 4, consecutive faulty checks before a replica is marked failed (1..15)

Ports:
- `clk`  in  1  single clock, rising edge
- `rst`  in  1  synchronous, active-high reset
- `start`  in  1  level; begin counting from IDLE
- `stop`  in  1  level; return to IDLE
- `q_1`, `q_2`, `q_3`  in  `width`  replica outputs of the TMR counter
- `enable`  out  1  registered count enable to all three replicas
- `resync`  out  1  registered one-cycle pulse; replicas reload from majority
- `fault_cnt_1`, `fault_cnt_2`, `fault_cnt_3`  out  `cnt_w`  saturating faulty-check totals
- `replica_failed`  out  3  sticky failed flag per replica (bit 0 = replica 1)
- `alarm`  out  1  no majority, or ≥2 replicas failed
- `state`  out  3  IDLE=0, RUN=1, CHECK=2, RESYNC=3, HALT=4

## Operation
- Majority logic is internal and combinational: `e12 = (q_1==q_2)`, `e13`, `e23`. Majority exists iff any `eXY`. Replica i is faulty iff majority exists and `q_i` ≠ majority value.
- IDLE: `enable`=0. `start & !stop` → RUN, with the scrub timer loaded to `scrub_period-1`.
- RUN: `enable`=1. The timer decrements each cycle. Transitions, highest priority first:
  - no majority → HALT
  - `stop` → IDLE
  - timer==0 → CHECK
- CHECK: `enable`=0 for one cycle; replica values are stable. Evaluate faults.
  - No majority → HALT.
  - Any replica faulty → RESYNC.
  - Otherwise → RUN with the timer reloaded. Consecutive counters of clean replicas clear to 0.
- RESYNC: `resync`=1 and `enable`=0 for one cycle.
  - For each faulty replica: `fault_cnt_i` +1, saturating at all-ones. Its 4-bit consecutive counter +1, saturating at 15. When the consecutive counter reaches `fail_thresh`, set `replica_failed[i]`; the flag is sticky.
  - Clean replicas clear their consecutive counter.
  - Next state: HALT if the popcount of the updated `replica_failed` is ≥2. Otherwise IDLE if `stop` is high. Otherwise RUN with the timer reloaded.
- HALT: `enable`=0, `alarm`=1. Only `rst` leaves HALT.
- `stop` asserted during CHECK is ignored. It is honoured in RESYNC or in the next RUN cycle.
- All statistics persist across IDLE. Only `rst` clears them.

## Timing
- All outputs are registered and reflect `state` of the same cycle. The `start` edge is seen as `enable`=1 one cycle later.
- Reset: `state`=IDLE, `enable`=0, `resync`=0, all `fault_cnt`=0, `replica_failed`=0, `alarm`=0, timer=0, consecutive counters=0. Reset mid-RESYNC suppresses the pulse on the following cycle.
- Steady loop with no faults: `scrub_period` RUN cycles, then 1 CHECK cycle. The counter advances `scrub_period` times per `scrub_period+1` cycles.
- Faulty loop: RUN → CHECK → RESYNC → RUN; 2 stall cycles.
- No-majority detection in RUN: `alarm`=1 on the next cycle. `enable` drops on that same cycle.

## Test plan
- Reset, then `start`=1 with replicas tracking identically, `scrub_period`=16 → `enable` high 16 cycles, low 1 cycle (`state`=2), repeating; `resync` never pulses; all `fault_cnt`=0.
- Force `q_2`=0x5 while `q_1`=`q_3`=0x9 at a CHECK → next cycle `resync`=1, `state`=3; then `fault_cnt_2`=1, others 0; RUN resumes.
- Hold `q_3` faulty for 4 consecutive checks, `fail_thresh`=4 → `replica_failed`=3'b100 after the 4th RESYNC; `alarm`=0. A clean check after 3 faulty checks instead leaves `replica_failed`=0.
- Set `q_1`=1, `q_2`=2, `q_3`=3 during RUN → next cycle `state`=4, `alarm`=1, `enable`=0. `start` and `stop` are then ignored until `rst`.
- Fail replica 1, then replica 2 → HALT on the RESYNC that sets the second flag. Separately, `fault_cnt_1` with `cnt_w`=2 saturates at 3 after 5 faults.
- Assert `stop` and `start` together in IDLE → stays IDLE. Assert `stop` during CHECK with a fault present → RESYNC, then IDLE, with `enable` remaining 0.
